dest_track_pipe: RTL and testbench
==================================

Name: dest_track_pipe

Overview:
- Tracks destination-register metadata (valid, write-enable, rd, is_load) through the EX, MEM and WB pipeline registers.
- Drives the write-enable/destination pairs that the forwarding unit consumes: EX/MEM as the "1d" pair, MEM/WB as the "2d" pair.
- Detects load-use hazards against the instruction in ID and inserts one bubble per hazard.
- Sits between the decode stage and the forwarding/hazard logic.

Parameters:
REGFILE_LOGSIZE, 5, width of register index fields.
CNT_W, 16, width of saturating load-use stall counter.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
id_valid  in  1  ID stage holds a real instruction.
id_we  in  1  ID instruction writes the register file.
id_is_load  in  1  ID instruction is a load.
id_rd  in  REGFILE_LOGSIZE  ID destination register.
id_rs1  in  REGFILE_LOGSIZE  ID source register 1.
id_rs2  in  REGFILE_LOGSIZE  ID source register 2.
id_uses_rs1  in  1  ID instruction reads rs1.
id_uses_rs2  in  1  ID instruction reads rs2.
stall_ext  in  1  global pipeline freeze (memory wait); all stages hold.
flush  in  1  branch redirect resolved in EX; ID instruction must not enter EX.
ex_regwrs  out  1  EX-stage instruction writes a register.
ex_regw  out  REGFILE_LOGSIZE  EX-stage destination.
regwrs_1d  out  1  EX/MEM write enable (to forwarding unit).
regw_1d  out  REGFILE_LOGSIZE  EX/MEM destination.
regwrs_2d  out  1  MEM/WB write enable (to forwarding unit).
regw_2d  out  REGFILE_LOGSIZE  MEM/WB destination.
load_use_stall  out  1  hold IF/ID, bubble into EX (combinational).
stall_cnt  out  CNT_W  saturating count of load-use bubbles inserted.

Behaviour:
- State: three entries EX, MEM, WB. Each entry holds {v, we, ld, rd}. A bubble is v=0, we=0, ld=0, rd=0.
- Reset (rst_n=0, asynchronous):
  - All entries become bubbles and stall_cnt=0.
  - All outputs read 0 while reset is asserted and in the first cycle after release.
  - Reset asserted mid-flight discards all tracked instructions immediately, with no clock edge required.
- Output decode:
  - regwrs_1d = MEM.v & MEM.we & (MEM.rd!=0); regw_1d = MEM.rd. The "1d" pair is the EX/MEM register.
  - regwrs_2d = WB.v & WB.we & (WB.rd!=0); regw_2d = WB.rd. The "2d" pair is the MEM/WB register.
  - ex_regwrs and ex_regw are decoded the same way from the EX entry.
- load_use_stall:
  - Asserted when id_valid & EX.v & EX.ld & EX.we & (EX.rd!=0) & ((id_uses_rs1 & id_rs1==EX.rd) | (id_uses_rs2 & id_rs2==EX.rd)).
  - Combinational from registered state and ID inputs; zero latency.
- Clock edge with stall_ext=1: every entry holds, stall_cnt holds. stall_ext has priority over flush and load_use_stall.
- Clock edge with stall_ext=0:
  - WB<=MEM and MEM<=EX.
  - EX<=bubble if flush=1 or load_use_stall=1; otherwise EX<={id_valid, id_we&id_valid, id_is_load&id_valid, id_rd}.
- Stall counter: stall_cnt increments when load_use_stall=1 & stall_ext=0 & flush=0, and saturates at all-ones.
- flush and load_use_stall together: a bubble enters EX and the counter does not increment.
- Latency: an instruction accepted from ID appears on ex_* 1 cycle later, on the 1d pair 2 cycles later and on the 2d pair 3 cycles later (absent stall_ext).
- A load-use hazard produces exactly one bubble. On the next edge the load moves to MEM, so the stall deasserts and the dependent instruction enters EX. The forwarding unit then selects MEM/WB data one cycle later.
- rd=0 never asserts a write enable or a stall, regardless of we.

Test Plan:
- Reset: hold rst_n=0 with id_valid=1, id_we=1, id_rd=7 for 3 clocks, then release -> every output is 0 throughout reset and for the first cycle after release.
- Propagation: at cycle 0 issue we=1, rd=5 with no stalls -> ex_regw=5 at cycle 1, regw_1d=5/regwrs_1d=1 at cycle 2, regw_2d=5/regwrs_2d=1 at cycle 3, and the 2d pair is 0 at cycle 4 if bubbles follow.
- Load-use: a load with rd=3 in EX and ID presenting rs2=3, uses_rs2=1 -> load_use_stall=1 for exactly one cycle and ex_regwrs=0 on the next cycle. The dependent instruction enters EX the cycle after, and stall_cnt goes 0->1.
- No false stall: EX holds a non-load with rd=3, or a load with rd=0, or ID has uses_rs2=0 -> load_use_stall stays 0 and stall_cnt is unchanged.
- Freeze and flush: with rd=4 in MEM, assert stall_ext for 2 cycles -> regw_1d=4 is held for both cycles. Then assert flush with ID valid rd=9 -> EX becomes a bubble (ex_regwrs=0) while MEM<=EX advances normally.
- Saturation: with CNT_W=4, force 20 consecutive load-use bubbles -> stall_cnt stops at 15. Asserting rst_n low mid-sequence clears it to 0 asynchronously.

Source files
------------

// File: rtl/dest_track_pipe.sv
// dest_track_pipe: EX/MEM/WB destination tracking, forwarding write-enable pairs and load-use bubble insertion
module dest_track_pipe #(
  parameter int REGFILE_LOGSIZE = 5,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       id_valid,
  input  logic                       id_we,
  input  logic                       id_is_load,
  input  logic [REGFILE_LOGSIZE-1:0] id_rd,
  input  logic [REGFILE_LOGSIZE-1:0] id_rs1,
  input  logic [REGFILE_LOGSIZE-1:0] id_rs2,
  input  logic                       id_uses_rs1,
  input  logic                       id_uses_rs2,
  input  logic                       stall_ext,
  input  logic                       flush,
  output logic                       ex_regwrs,
  output logic [REGFILE_LOGSIZE-1:0] ex_regw,
  output logic                       regwrs_1d,
  output logic [REGFILE_LOGSIZE-1:0] regw_1d,
  output logic                       regwrs_2d,
  output logic [REGFILE_LOGSIZE-1:0] regw_2d,
  output logic                       load_use_stall,
  output logic [CNT_W-1:0]           stall_cnt
);
  typedef struct packed {
    logic                       v;
    logic                       we;
    logic                       ld;
    logic [REGFILE_LOGSIZE-1:0] rd;
  } ent_t;
  ent_t ex, mem, wb;
  always_comb begin
    ex_regwrs = ex.v & ex.we & (|ex.rd);
    ex_regw = ex.rd;
    regwrs_1d = mem.v & mem.we & (|mem.rd);
    regw_1d = mem.rd;
    regwrs_2d = wb.v & wb.we & (|wb.rd);
    regw_2d = wb.rd;
    load_use_stall = id_valid & ex.v & ex.ld & ex.we & (|ex.rd) &
                     ((id_uses_rs1 & (id_rs1 == ex.rd)) | (id_uses_rs2 & (id_rs2 == ex.rd)));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex <= '0;
      mem <= '0;
      wb <= '0;
      stall_cnt <= '0;
    end else if (!stall_ext) begin
      wb <= mem;
      mem <= ex;
      ex <= (flush | load_use_stall) ? '0 : {id_valid, id_we & id_valid, id_is_load & id_valid, id_rd};
      if (load_use_stall && !flush && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_dest_track_pipe.sv
// tb_dest_track_pipe: directed vector table plus randomized run against a queue-based pipeline model
module tb_dest_track_pipe;
  localparam int RW = 5;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid, id_we, id_is_load, id_uses_rs1, id_uses_rs2, stall_ext, flush;
  logic [RW-1:0] id_rd, id_rs1, id_rs2;
  logic ex_regwrs, regwrs_1d, regwrs_2d, load_use_stall;
  logic [RW-1:0] ex_regw, regw_1d, regw_2d;
  logic [CW-1:0] stall_cnt;
  always #5 clk = ~clk;
  dest_track_pipe #(.REGFILE_LOGSIZE(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_we(id_we), .id_is_load(id_is_load),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .stall_ext(stall_ext), .flush(flush),
    .ex_regwrs(ex_regwrs), .ex_regw(ex_regw), .regwrs_1d(regwrs_1d), .regw_1d(regw_1d),
    .regwrs_2d(regwrs_2d), .regw_2d(regw_2d), .load_use_stall(load_use_stall), .stall_cnt(stall_cnt)
  );
  typedef struct packed {
    logic v, we, ld, u1, u2, sx, fl;
    logic [RW-1:0] rd, rs1, rs2;
  } in_t;
  typedef struct {
    bit v, we, ld;
    int rd;
  } ent_t;
  typedef struct {
    in_t i;
    int ew, er, w1, r1, w2, r2, lu, cnt;
  } vec_t;
  ent_t pipe[$];
  int mcnt;
  int checks = 0;
  int errors = 0;
  vec_t tbl[21];
  function automatic in_t mk(int v, int we, int ld, int rd, int rs1, int u1, int rs2, int u2, int sx, int fl);
    in_t s;
    s.v = v[0]; s.we = we[0]; s.ld = ld[0]; s.u1 = u1[0]; s.u2 = u2[0]; s.sx = sx[0]; s.fl = fl[0];
    s.rd = RW'(rd); s.rs1 = RW'(rs1); s.rs2 = RW'(rs2);
    return s;
  endfunction
  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endfunction
  task automatic apply(in_t s);
    id_valid = s.v; id_we = s.we; id_is_load = s.ld; id_rd = s.rd;
    id_rs1 = s.rs1; id_rs2 = s.rs2; id_uses_rs1 = s.u1; id_uses_rs2 = s.u2;
    stall_ext = s.sx; flush = s.fl;
  endtask
  function automatic bit writes(ent_t e);
    return e.v && e.we && e.rd != 0;
  endfunction
  function automatic bit hazard(in_t s);
    ent_t e = pipe[0];
    return s.v && e.v && e.ld && writes(e) &&
           ((s.u1 && int'(s.rs1) == e.rd) || (s.u2 && int'(s.rs2) == e.rd));
  endfunction
  task automatic model_reset();
    ent_t b = '{0, 0, 0, 0};
    pipe = {b, b, b};
    mcnt = 0;
  endtask
  task automatic model_step(in_t s);
    ent_t n = '{0, 0, 0, 0};
    bit h = hazard(s);
    if (!s.sx) begin
      if (!(s.fl || h)) n = '{s.v, s.we && s.v, s.ld && s.v, int'(s.rd)};
      void'(pipe.pop_back());
      pipe.push_front(n);
      if (h && !s.fl && mcnt < CMAX) mcnt++;
    end
  endtask
  task automatic model_check(in_t s);
    chk("ex_regwrs", ex_regwrs, writes(pipe[0]));
    chk("ex_regw", ex_regw, pipe[0].rd);
    chk("regwrs_1d", regwrs_1d, writes(pipe[1]));
    chk("regw_1d", regw_1d, pipe[1].rd);
    chk("regwrs_2d", regwrs_2d, writes(pipe[2]));
    chk("regw_2d", regw_2d, pipe[2].rd);
    chk("load_use_stall", load_use_stall, hazard(s));
    chk("stall_cnt", stall_cnt, mcnt);
  endtask
  task automatic check_zero(string n);
    chk({n, "_ex_regwrs"}, ex_regwrs, 0);
    chk({n, "_ex_regw"}, ex_regw, 0);
    chk({n, "_regwrs_1d"}, regwrs_1d, 0);
    chk({n, "_regw_1d"}, regw_1d, 0);
    chk({n, "_regwrs_2d"}, regwrs_2d, 0);
    chk({n, "_regw_2d"}, regw_2d, 0);
    chk({n, "_load_use_stall"}, load_use_stall, 0);
    chk({n, "_stall_cnt"}, stall_cnt, 0);
  endtask
  task automatic cycle(in_t s);
    apply(s);
    #1;
    model_check(s);
    model_step(s);
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    in_t idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    in_t ldrep = mk(1, 1, 1, 3, 3, 1, 0, 0, 0, 0);
    // each row: inputs this cycle, then outputs expected before the edge that consumes them
    tbl[0]  = '{mk(1,1,0,5,0,0,0,0,0,0), 0,0, 0,0, 0,0, 0,0};
    tbl[1]  = '{idle,                    1,5, 0,0, 0,0, 0,0};
    tbl[2]  = '{idle,                    0,0, 1,5, 0,0, 0,0};
    tbl[3]  = '{mk(1,1,1,3,0,0,0,0,0,0), 0,0, 0,0, 1,5, 0,0};
    tbl[4]  = '{mk(1,1,0,6,0,0,3,1,0,0), 1,3, 0,0, 0,0, 1,0};
    tbl[5]  = '{mk(1,1,0,6,0,0,3,1,0,0), 0,0, 1,3, 0,0, 0,1};
    tbl[6]  = '{idle,                    1,6, 0,0, 1,3, 0,1};
    tbl[7]  = '{mk(1,1,0,3,0,0,0,0,0,0), 0,0, 1,6, 0,0, 0,1};
    tbl[8]  = '{mk(1,0,0,0,0,0,3,1,0,0), 1,3, 0,0, 1,6, 0,1};
    tbl[9]  = '{mk(1,1,1,0,0,0,0,0,0,0), 0,0, 1,3, 0,0, 0,1};
    tbl[10] = '{mk(1,0,0,0,0,1,0,1,0,0), 0,0, 0,0, 1,3, 0,1};
    tbl[11] = '{mk(1,1,1,3,0,0,0,0,0,0), 0,0, 0,0, 0,0, 0,1};
    tbl[12] = '{mk(1,1,0,4,2,1,3,0,0,0), 1,3, 0,0, 0,0, 0,1};
    tbl[13] = '{idle,                    1,4, 1,3, 0,0, 0,1};
    tbl[14] = '{mk(0,0,0,0,0,0,0,0,1,0), 0,0, 1,4, 1,3, 0,1};
    tbl[15] = '{mk(0,0,0,0,0,0,0,0,1,0), 0,0, 1,4, 1,3, 0,1};
    tbl[16] = '{mk(1,1,0,9,0,0,0,0,0,1), 0,0, 1,4, 1,3, 0,1};
    tbl[17] = '{idle,                    0,0, 0,0, 1,4, 0,1};
    tbl[18] = '{mk(1,1,1,7,0,0,0,0,0,0), 0,0, 0,0, 0,0, 0,1};
    tbl[19] = '{mk(1,1,0,2,7,1,0,0,0,1), 1,7, 0,0, 0,0, 1,1};
    tbl[20] = '{idle,                    0,0, 1,7, 0,0, 0,1};
    apply(mk(1, 1, 0, 7, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_zero("in_reset");
    end
    rst_n = 1'b1;
    #1;
    check_zero("after_release");
    model_reset();
    cycle(idle);
    for (int k = 0; k < 21; k++) begin
      apply(tbl[k].i);
      #1;
      chk($sformatf("v%0d_ex_regwrs", k), ex_regwrs, tbl[k].ew);
      chk($sformatf("v%0d_ex_regw", k), ex_regw, tbl[k].er);
      chk($sformatf("v%0d_regwrs_1d", k), regwrs_1d, tbl[k].w1);
      chk($sformatf("v%0d_regw_1d", k), regw_1d, tbl[k].r1);
      chk($sformatf("v%0d_regwrs_2d", k), regwrs_2d, tbl[k].w2);
      chk($sformatf("v%0d_regw_2d", k), regw_2d, tbl[k].r2);
      chk($sformatf("v%0d_load_use_stall", k), load_use_stall, tbl[k].lu);
      chk($sformatf("v%0d_stall_cnt", k), stall_cnt, tbl[k].cnt);
      model_step(tbl[k].i);
      @(posedge clk);
      @(negedge clk);
    end
    for (int k = 0; k < 600; k++)
      cycle(mk($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
               $urandom_range(0, 3), $urandom_range(0, 1),
               $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0));
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid_random");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 44; k++) cycle(ldrep);
    chk("saturated_cnt", stall_cnt, CMAX);
    apply(ldrep);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_clear");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 6; k++) cycle(ldrep);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
